cordic_engine: RTL and testbench



---
 rtl/cordic_pkg.sv | 67 ++++++
 rtl/cordic_microrot.sv | 39 +++
 rtl/cordic_engine.sv | 168 ++++++++++++++++
 tb/tb_cordic_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC core: arctangent table, pi/2 and
// inverse-gain constants rescaled to any fraction width, and the mode enum.
package cordic_pkg;

  typedef enum logic {ROTATE = 1'b0, VECTOR = 1'b1} cordic_mode_e;

  localparam int ATAN_FRAC = 30;

  // atan(2^-i) * 2^30, rounded
  function automatic int atan_raw(input int i);
    case (i)
      0:  return 843314857;
      1:  return 497837830;
      2:  return 263043837;
      3:  return 133525159;
      4:  return 67021687;
      5:  return 33543516;
      6:  return 16775851;
      7:  return 8388437;
      8:  return 4194283;
      9:  return 2097149;
      10: return 1048576;
      11: return 524288;
      12: return 262144;
      13: return 131072;
      14: return 65536;
      15: return 32768;
      16: return 16384;
      17: return 8192;
      18: return 4096;
      19: return 2048;
      20: return 1024;
      21: return 512;
      22: return 256;
      23: return 128;
      24: return 64;
      25: return 32;
      26: return 16;
      27: return 8;
      28: return 4;
      29: return 2;
      30: return 1;
      31: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int rnd_shr(input longint v, input int s);
    longint r;
    if (s <= 0) r = v <<< (-s);
    else        r = (v + (64'sd1 <<< (s - 1))) >>> s;
    return int'(r);
  endfunction

  function automatic int atan_q(input int i, input int frac);
    return rnd_shr(longint'(atan_raw(i)), ATAN_FRAC - frac);
  endfunction

  function automatic int half_pi(input int frac);
    return rnd_shr(64'sd1686629713, ATAN_FRAC - frac);
  endfunction

  function automatic int inv_gain(input int frac);
    return rnd_shr(64'sd652032874, ATAN_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation; direction comes from z (rotate)
// or from the sign of y (vector).
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int XW = 20,
  parameter int ZW = 19
) (
  input  cordic_mode_e           mode,
  input  logic signed [XW-1:0]   x,
  input  logic signed [XW-1:0]   y,
  input  logic signed [ZW-1:0]   z,
  input  logic        [4:0]      shift,
  input  logic signed [ZW-1:0]   atan,
  output logic signed [XW-1:0]   x_nxt,
  output logic signed [XW-1:0]   y_nxt,
  output logic signed [ZW-1:0]   z_nxt
);

  logic                 pos;
  logic signed [XW-1:0] xs, ys;

  assign pos = (mode == ROTATE) ? ~z[ZW-1] : y[XW-1];
  assign xs  = x >>> shift;
  assign ys  = y >>> shift;

  always_comb begin
    if (pos) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: quadrant pre-rotation on accept, UNROLL chained
// micro-rotations per RUN cycle, saturated result held in DONE until taken.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int ITERS  = 16,
  parameter int UNROLL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [WIDTH-1:0] in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [WIDTH-1:0] out_z
);

  localparam int FRAC = WIDTH - 3;
  localparam int XW   = WIDTH + 2;
  localparam int ZW   = WIDTH + 1;

  localparam logic signed [ZW-1:0] HALF_PI = ZW'(half_pi(FRAC));
  localparam logic signed [XW-1:0] XMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] XMIN = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic signed [ZW-1:0] ZMAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [ZW-1:0] ZMIN = {2'b11, {(WIDTH-1){1'b0}}};

  generate
    if (ITERS % UNROLL != 0) begin : g_bad_unroll
      $error("cordic_engine: ITERS must be a multiple of UNROLL");
    end
    if (ITERS < 1 || ITERS > 32 || ITERS > FRAC + 1) begin : g_bad_iters
      $error("cordic_engine: ITERS out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state, state_nxt;
  cordic_mode_e         mode_r;
  logic [5:0]           iter;
  logic signed [XW-1:0] x_r, y_r;
  logic signed [ZW-1:0] z_r;
  logic                 accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (iter + 6'(UNROLL)) == 6'(ITERS);

  // Fold the operand into the right half-plane so the micro-rotations converge
  logic signed [XW-1:0] ix, iy, px, py;
  logic signed [ZW-1:0] iz, pz;

  assign ix = XW'(in_x);
  assign iy = XW'(in_y);
  assign iz = ZW'(in_z);

  always_comb begin
    px = ix;
    py = iy;
    pz = iz;
    if (cordic_mode_e'(in_mode) == VECTOR) begin
      if (ix < 0) begin
        if (iy >= 0) begin px = iy;  py = -ix; pz = iz + HALF_PI; end
        else         begin px = -iy; py = ix;  pz = iz - HALF_PI; end
      end
    end else begin
      if      (iz > HALF_PI)  begin px = -iy; py = ix;  pz = iz - HALF_PI; end
      else if (iz < -HALF_PI) begin px = iy;  py = -ix; pz = iz + HALF_PI; end
    end
  end

  logic [UNROLL:0][XW-1:0] xc, yc;
  logic [UNROLL:0][ZW-1:0] zc;

  assign xc[0] = x_r;
  assign yc[0] = y_r;
  assign zc[0] = z_r;

  for (genvar k = 0; k < UNROLL; k++) begin : g_rot
    logic [5:0]           idx;
    logic signed [ZW-1:0] at;
    assign idx = iter + 6'(k);
    assign at  = ZW'(atan_q(int'(idx), FRAC));
    cordic_microrot #(.XW(XW), .ZW(ZW)) u_rot (
      .mode  (mode_r),
      .x     (xc[k]),
      .y     (yc[k]),
      .z     (zc[k]),
      .shift (idx[4:0]),
      .atan  (at),
      .x_nxt (xc[k+1]),
      .y_nxt (yc[k+1]),
      .z_nxt (zc[k+1])
    );
  end

  function automatic logic signed [WIDTH-1:0] sat_xy(input logic signed [XW-1:0] v);
    if (v > XMAX)      return XMAX[WIDTH-1:0];
    else if (v < XMIN) return XMIN[WIDTH-1:0];
    else               return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_z(input logic signed [ZW-1:0] v);
    if (v > ZMAX)      return ZMAX[WIDTH-1:0];
    else if (v < ZMIN) return ZMIN[WIDTH-1:0];
    else               return v[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r   <= ROTATE;
      iter     <= '0;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      out_mode <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
    end else if (accept) begin
      mode_r <= cordic_mode_e'(in_mode);
      iter   <= '0;
      x_r    <= px;
      y_r    <= py;
      z_r    <= pz;
    end else if (state == RUN) begin
      iter <= iter + 6'(UNROLL);
      x_r  <= xc[UNROLL];
      y_r  <= yc[UNROLL];
      z_r  <= zc[UNROLL];
      if (last) begin
        out_mode <= mode_r;
        out_x    <= sat_xy(xc[UNROLL]);
        out_y    <= sat_xy(yc[UNROLL]);
        out_z    <= sat_z(zc[UNROLL]);
      end
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Bench for cordic_engine: directed handshake/quadrant/saturation/reset cases
// plus random operands checked against a floating-point CORDIC-gain model.
module tb_cordic_engine;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic signed [17:0] in_x, in_y, in_z, out_x, out_y, out_z;

  logic in_valid_s, in_ready_s, in_mode_s, out_valid_s, out_ready_s, out_mode_s;
  logic signed [15:0] in_x_s, in_y_s, in_z_s, out_x_s, out_y_s, out_z_s;

  always #5 clk = ~clk;

  cordic_engine u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  cordic_engine #(.WIDTH(16), .ITERS(12), .UNROLL(3)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_mode(in_mode_s),
    .in_x(in_x_s), .in_y(in_y_s), .in_z(in_z_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_mode(out_mode_s),
    .out_x(out_x_s), .out_y(out_y_s), .out_z(out_z_s)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int act, input int exp, input int tol);
    n_chk++;
    if (act - exp > tol || exp - act > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (+-%0d)", tag, act, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Issue one operand from IDLE and wait for out_valid; lat = cycles after accept
  task automatic issue_wait(input logic m, input int x, input int y, input int z, output int lat);
    @(negedge clk);
    check("accept_ready", int'(in_ready), 1, 0);
    in_valid = 1'b1; in_mode = m;
    in_x = 18'(x); in_y = 18'(y); in_z = 18'(z);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  real K;
  int  lat, ox, oy, oz, seen;

  initial begin
    rst = 1'b1;
    in_valid = 0; in_mode = 0; in_x = 0; in_y = 0; in_z = 0; out_ready = 0;
    in_valid_s = 0; in_mode_s = 0; in_x_s = 0; in_y_s = 0; in_z_s = 0; out_ready_s = 0;
    K = 1.0;
    for (int i = 0; i < 16; i++) K = K * $sqrt(1.0 + $pow(2.0, -2.0 * i));

    repeat (3) @(negedge clk);
    check("rst_in_ready_forced", int'(in_ready), 0, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_mode", int'(out_mode), 0, 0);
    check("rst_out_x", int'(out_x), 0, 0);
    check("rst_out_y", int'(out_y), 0, 0);
    check("rst_out_z", int'(out_z), 0, 0);
    check("rst_s_out_valid", int'(out_valid_s), 0, 0);

    // Unit-gain sin/cos at pi/6
    issue_wait(1'b0, 19898, 0, 17157, lat);
    check("rot_lat", lat, 5, 0);
    check("rot_x", int'(out_x), 28378, 4);
    check("rot_y", int'(out_y), 16384, 4);
    check("rot_mode", int'(out_mode), 0, 0);
    drain();

    issue_wait(1'b0, 19898, 0, 77208, lat);
    check("q2_x", int'(out_x), -23170, 4);
    check("q2_y", int'(out_y), 23170, 4);
    drain();
    issue_wait(1'b0, 19898, 0, -77208, lat);
    check("q3_x", int'(out_x), -23170, 4);
    check("q3_y", int'(out_y), -23170, 4);
    drain();

    issue_wait(1'b1, -16384, 16384, 0, lat);
    check("vec_lat", lat, 5, 0);
    check("vec_mode", int'(out_mode), 1, 0);
    check("vec_z", int'(out_z), 77208, 4);
    check("vec_x", int'(out_x), 38157, 6);
    check("vec_y", int'(out_y), 0, 4);
    drain();
    issue_wait(1'b1, 16384, 0, 0, lat);
    check("vec0_z", int'(out_z), 0, 4);
    drain();

    // Gain overflow must clamp, not wrap
    issue_wait(1'b0, 131071, 0, 0, lat);
    check("sat_pos_x", int'(out_x), 131071, 0);
    drain();
    issue_wait(1'b0, -131072, 0, 0, lat);
    check("sat_neg_x", int'(out_x), -131072, 0);
    drain();
    issue_wait(1'b1, 131071, 131071, 0, lat);
    check("sat_vec_x", int'(out_x), 131071, 0);
    check("sat_vec_z", int'(out_z), 25736, 4);
    drain();

    // Backpressure: result held, new operand waits for out_ready
    issue_wait(1'b0, 19898, 0, 17157, lat);
    ox = int'(out_x); oy = int'(out_y); oz = int'(out_z);
    in_valid = 1'b1; in_mode = 1'b0; in_x = 18'sd19898; in_y = 18'sd0; in_z = -18'sd17157;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || int'(out_x) != ox || int'(out_y) != oy || int'(out_z) != oz)
        seen++;
    end
    check("bp_hold", seen, 0, 0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_passthru", int'(in_ready), 1, 0);
    @(negedge clk);
    out_ready = 1'b0;
    in_x = 18'sd5000; in_z = 18'sd50000;  // must be ignored while running
    lat = 1; seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) seen++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("b2b_lat", lat, 5, 0);
    check("run_ready_low", seen, 0, 0);
    check("b2b_x", int'(out_x), 28378, 4);
    check("b2b_y", int'(out_y), -16384, 4);
    drain();

    // Reset on the second RUN cycle aborts the operation
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_x = 18'sd19898; in_y = 18'sd0; in_z = 18'sd17157;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1, 0);
    check("abort_x", int'(out_x), 0, 0);
    check("abort_y", int'(out_y), 0, 0);
    check("abort_z", int'(out_z), 0, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0, 0);
    issue_wait(1'b1, 16384, 16384, 0, lat);
    check("post_rst_lat", lat, 5, 0);
    check("post_rst_z", int'(out_z), 25736, 4);
    drain();

    // Random operands against the ideal rotation/vectoring result times K
    for (int n = 0; n < 24; n++) begin
      logic m;
      int x, y, z;
      real ex, ey, ez, a;
      m = 1'($urandom_range(1));
      x = int'($urandom_range(80000)) - 40000;
      y = int'($urandom_range(80000)) - 40000;
      if (m) begin
        while ($sqrt(real'(x) * x + real'(y) * y) < 16384.0) begin
          x = int'($urandom_range(80000)) - 40000;
          y = int'($urandom_range(80000)) - 40000;
        end
        z  = int'($urandom_range(2000)) - 1000;
        ex = K * $sqrt(real'(x) * x + real'(y) * y);
        ey = 0.0;
        ez = z + $atan2(real'(y), real'(x)) * 32768.0;
      end else begin
        z  = int'($urandom_range(205886)) - 102943;
        a  = z / 32768.0;
        ex = K * (x * $cos(a) - y * $sin(a));
        ey = K * (x * $sin(a) + y * $cos(a));
        ez = 0.0;
      end
      issue_wait(m, x, y, z, lat);
      check("rnd_lat", lat, 5, 0);
      check("rnd_mode", int'(out_mode), int'(m), 0);
      check("rnd_x", int'(out_x), rnd(ex), 12);
      check("rnd_y", int'(out_y), rnd(ey), 12);
      check("rnd_z", int'(out_z), rnd(ez), 10);
      drain();
    end

    // Narrow instance: WIDTH=16, ITERS=12, UNROLL=3, 45 degrees
    @(negedge clk);
    check("s_accept_ready", int'(in_ready_s), 1, 0);
    in_valid_s = 1'b1; in_mode_s = 1'b0; in_x_s = 16'sd4975; in_y_s = 16'sd0; in_z_s = 16'sd6434;
    @(negedge clk);
    in_valid_s = 1'b0;
    lat = 1;
    while (!out_valid_s && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("s_lat", lat, 5, 0);
    check("s_x", int'(out_x_s), 5793, 4);
    check("s_y", int'(out_y_s), 5793, 4);
    out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
